// File: rtl/glyph_tile_pkg.sv
// Shared definitions for the glyph tile address generator: glyph codes,
// the slot-table record and the sprite-sheet base-address lookup.
package glyph_tile_pkg;

    localparam logic [3:0] GLYPH_0     = 4'd0;
    localparam logic [3:0] GLYPH_1     = 4'd1;
    localparam logic [3:0] GLYPH_2     = 4'd2;
    localparam logic [3:0] GLYPH_3     = 4'd3;
    localparam logic [3:0] GLYPH_4     = 4'd4;
    localparam logic [3:0] GLYPH_5     = 4'd5;
    localparam logic [3:0] GLYPH_6     = 4'd6;
    localparam logic [3:0] GLYPH_7     = 4'd7;
    localparam logic [3:0] GLYPH_8     = 4'd8;
    localparam logic [3:0] GLYPH_9     = 4'd9;
    localparam logic [3:0] GLYPH_PLUS  = 4'd10;
    localparam logic [3:0] GLYPH_MINUS = 4'd11;
    localparam logic [3:0] GLYPH_MUL   = 4'd12;
    localparam logic [3:0] GLYPH_EQ    = 4'd13;
    localparam logic [3:0] GLYPH_BLANK = 4'd14;
    localparam logic [3:0] GLYPH_RSVD  = 4'd15;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] code;
        logic       vis;
        logic       blink;
    } slot_t;

    localparam slot_t SLOT_RESET = '{x: 10'd0, y: 10'd0, code: GLYPH_BLANK,
                                     vis: 1'b0, blink: 1'b0};

    // Blank and reserved codes have no sheet entry; callers treat them as misses.
    function automatic logic [15:0] glyph_base(input logic [3:0] code);
        case (code)
            GLYPH_0:     glyph_base = 16'd23080;
            GLYPH_1:     glyph_base = 16'd23112;
            GLYPH_2:     glyph_base = 16'd23135;
            GLYPH_3:     glyph_base = 16'd23160;
            GLYPH_4:     glyph_base = 16'd23185;
            GLYPH_5:     glyph_base = 16'd23215;
            GLYPH_6:     glyph_base = 16'd23242;
            GLYPH_7:     glyph_base = 16'd23270;
            GLYPH_8:     glyph_base = 16'd44200;
            GLYPH_9:     glyph_base = 16'd44230;
            GLYPH_PLUS:  glyph_base = 16'd44255;
            GLYPH_MINUS: glyph_base = 16'd44275;
            GLYPH_MUL:   glyph_base = 16'd44300;
            GLYPH_EQ:    glyph_base = 16'd44330;
            default:     glyph_base = 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/glyph_slot_match.sv
// Per-slot combinational window test: reports a hit and the pixel offset
// inside the glyph for the current scan position.
module glyph_slot_match
    import glyph_tile_pkg::*;
#(
    parameter int GLYPH_W = 20,
    parameter int GLYPH_H = 20
) (
    input  slot_t       i_slot,
    input  logic [9:0]  i_h_cnt,
    input  logic [9:0]  i_v_cnt,
    input  logic        i_blink_phase,
    output logic        o_hit,
    output logic [5:0]  o_dx,
    output logic [5:0]  o_dy
);

    logic [10:0] w_h;
    logic [10:0] w_v;
    logic [10:0] w_x;
    logic [10:0] w_y;
    logic [10:0] w_x_end;
    logic [10:0] w_y_end;
    logic        w_in_x;
    logic        w_in_y;
    logic        w_code_ok;

    // 11-bit window ends keep slots near the right/bottom edge from wrapping.
    assign w_h     = {1'b0, i_h_cnt};
    assign w_v     = {1'b0, i_v_cnt};
    assign w_x     = {1'b0, i_slot.x};
    assign w_y     = {1'b0, i_slot.y};
    assign w_x_end = w_x + 11'(GLYPH_W);
    assign w_y_end = w_y + 11'(GLYPH_H);

    assign w_in_x    = (w_h >= w_x) && (w_h < w_x_end);
    assign w_in_y    = (w_v >= w_y) && (w_v < w_y_end);
    assign w_code_ok = (i_slot.code != GLYPH_BLANK) && (i_slot.code != GLYPH_RSVD);

    assign o_hit = i_slot.vis && w_code_ok && w_in_x && w_in_y
                   && !(i_slot.blink && i_blink_phase);
    assign o_dx  = 6'(i_h_cnt - i_slot.x);
    assign o_dy  = 6'(i_v_cnt - i_slot.y);

endmodule

// File: rtl/glyph_tile_addr_gen.sv
// Two-stage scan-position to sprite-sheet address generator with a writable
// slot table. Blink gating and the frame counter exist only with GLYPH_TILE_BLINK_EN.
module glyph_tile_addr_gen
    import glyph_tile_pkg::*;
#(
    parameter int N_SLOTS   = 12,
    parameter int GLYPH_W   = 20,
    parameter int GLYPH_H   = 20,
    parameter int SHEET_W   = 320,
    parameter int ADDR_W    = 17,
    parameter int BG_ADDR   = 100,
    parameter int BLINK_BIT = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic              scan_valid,
    input  logic              slot_we,
    input  logic [3:0]        slot_idx,
    input  logic [9:0]        slot_x,
    input  logic [9:0]        slot_y,
    input  logic [3:0]        slot_code,
    input  logic              slot_vis,
    input  logic              slot_blink,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              pixel_addr_valid,
    output logic [3:0]        hit_slot
);

    slot_t              r_slots [N_SLOTS];
    logic               w_blink_phase;
    logic [N_SLOTS-1:0] w_hit;
    logic [5:0]         w_dx [N_SLOTS];
    logic [5:0]         w_dy [N_SLOTS];

    logic               w_any;
    logic [3:0]         w_idx;
    logic [5:0]         w_sel_dx;
    logic [5:0]         w_sel_dy;
    logic [15:0]        w_sel_base;

    logic               r1_valid;
    logic               r1_hit;
    logic [3:0]         r1_idx;
    logic [5:0]         r1_dx;
    logic [5:0]         r1_dy;
    logic [15:0]        r1_base;
    logic [31:0]        w_addr_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_SLOTS; i++) begin
                r_slots[i] <= SLOT_RESET;
            end
        end else if (slot_we && (32'(slot_idx) < N_SLOTS)) begin
            r_slots[slot_idx] <= '{x: slot_x, y: slot_y, code: slot_code,
                                   vis: slot_vis, blink: slot_blink};
        end
    end

`ifdef GLYPH_TILE_BLINK_EN
    logic [7:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (scan_valid && (h_cnt == '0) && (v_cnt == '0)) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign w_blink_phase = r_frame_cnt[BLINK_BIT];
`else
    // No frame counter: the phase is constant-false, so blinking slots always show.
    assign w_blink_phase = (BLINK_BIT < 0);
`endif

    for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_match
        glyph_slot_match #(
            .GLYPH_W (GLYPH_W),
            .GLYPH_H (GLYPH_H)
        ) u_match (
            .i_slot        (r_slots[gi]),
            .i_h_cnt       (h_cnt),
            .i_v_cnt       (v_cnt),
            .i_blink_phase (w_blink_phase),
            .o_hit         (w_hit[gi]),
            .o_dx          (w_dx[gi]),
            .o_dy          (w_dy[gi])
        );
    end

    // Lowest-index hit wins.
    always_comb begin
        w_any      = 1'b0;
        w_idx      = 4'hF;
        w_sel_dx   = '0;
        w_sel_dy   = '0;
        w_sel_base = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            if (w_hit[i] && !w_any) begin
                w_any      = 1'b1;
                w_idx      = 4'(i);
                w_sel_dx   = w_dx[i];
                w_sel_dy   = w_dy[i];
                w_sel_base = glyph_base(r_slots[i].code);
            end
        end
    end

    assign w_addr_full = 32'(r1_base) + 32'(r1_dx) + 32'(SHEET_W) * 32'(r1_dy);

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid         <= 1'b0;
            r1_hit           <= 1'b0;
            r1_idx           <= 4'hF;
            r1_dx            <= '0;
            r1_dy            <= '0;
            r1_base          <= '0;
            pixel_addr       <= ADDR_W'(BG_ADDR);
            pixel_addr_valid <= 1'b0;
            hit_slot         <= 4'hF;
        end else begin
            r1_valid         <= scan_valid;
            r1_hit           <= w_any;
            r1_idx           <= w_idx;
            r1_dx            <= w_sel_dx;
            r1_dy            <= w_sel_dy;
            r1_base          <= w_sel_base;
            pixel_addr       <= r1_hit ? w_addr_full[ADDR_W-1:0] : ADDR_W'(BG_ADDR);
            pixel_addr_valid <= r1_valid;
            hit_slot         <= r1_hit ? r1_idx : 4'hF;
        end
    end

endmodule

// File: tb/tb_glyph_tile_addr_gen.sv
// Self-checking bench for glyph_tile_addr_gen: directed literal cases plus
// randomized traffic compared every cycle against a behavioural model.
module tb_glyph_tile_addr_gen;

    localparam int N_SLOTS = 12;
    localparam int GW      = 20;
    localparam int GH      = 20;
    localparam int SHEET   = 320;
    localparam int BG      = 100;
    localparam int BLINK_B = 5;

    logic        clk;
    logic        rst;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        scan_valid;
    logic        slot_we;
    logic [3:0]  slot_idx;
    logic [9:0]  slot_x;
    logic [9:0]  slot_y;
    logic [3:0]  slot_code;
    logic        slot_vis;
    logic        slot_blink;
    logic [16:0] pixel_addr;
    logic        pixel_addr_valid;
    logic [3:0]  hit_slot;

    int n_checks = 0;
    int n_err    = 0;

    glyph_tile_addr_gen dut (
        .clk              (clk),
        .rst              (rst),
        .h_cnt            (h_cnt),
        .v_cnt            (v_cnt),
        .scan_valid       (scan_valid),
        .slot_we          (slot_we),
        .slot_idx         (slot_idx),
        .slot_x           (slot_x),
        .slot_y           (slot_y),
        .slot_code        (slot_code),
        .slot_vis         (slot_vis),
        .slot_blink       (slot_blink),
        .pixel_addr       (pixel_addr),
        .pixel_addr_valid (pixel_addr_valid),
        .hit_slot         (hit_slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: slot table, frame count, and the expected outputs.
    int BASE [16] = '{23080, 23112, 23135, 23160, 23185, 23215, 23242, 23270,
                      44200, 44230, 44255, 44275, 44300, 44330, 0, 0};
    int m_x [N_SLOTS];
    int m_y [N_SLOTS];
    int m_code [N_SLOTS];
    bit m_vis [N_SLOTS];
    bit m_blink [N_SLOTS];
    int m_frames;

    typedef struct { int addr; int hit; int valid; } exp_t;
    exp_t exp_prev, exp_cur;
    bit   model_live = 1'b0;

    function automatic exp_t model_pixel(int h, int v, int sv);
        exp_t e;
        bit   ph;
        e.addr  = BG;
        e.hit   = 15;
        e.valid = sv;
`ifdef GLYPH_TILE_BLINK_EN
        ph = ((m_frames >> BLINK_B) & 1) == 1;
`else
        ph = 1'b0;
`endif
        for (int i = 0; i < N_SLOTS; i++) begin
            if (e.hit == 15 && m_vis[i] && m_code[i] < 14 &&
                h >= m_x[i] && h < m_x[i] + GW &&
                v >= m_y[i] && v < m_y[i] + GH &&
                !(m_blink[i] && ph)) begin
                e.hit  = i;
                e.addr = (BASE[m_code[i]] + (h - m_x[i]) + SHEET * (v - m_y[i])) % (1 << 17);
            end
        end
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                m_x[i] = 0; m_y[i] = 0; m_code[i] = 14; m_vis[i] = 0; m_blink[i] = 0;
            end
            m_frames       = 0;
            exp_cur        = '{addr: BG, hit: 15, valid: 0};
            exp_prev       = '{addr: BG, hit: 15, valid: 0};
        end else begin
            exp_cur  = exp_prev;
            exp_prev = model_pixel(int'(h_cnt), int'(v_cnt), int'(scan_valid));
            if (slot_we && slot_idx < N_SLOTS) begin
                m_x[slot_idx]     = int'(slot_x);
                m_y[slot_idx]     = int'(slot_y);
                m_code[slot_idx]  = int'(slot_code);
                m_vis[slot_idx]   = slot_vis;
                m_blink[slot_idx] = slot_blink;
            end
            if (scan_valid && h_cnt == 0 && v_cnt == 0) m_frames = (m_frames + 1) % 256;
        end
        model_live = 1'b1;
    end

    always @(posedge clk) begin
        #1;
        if (model_live) begin
            check("model_addr",  int'(pixel_addr),       exp_cur.addr);
            check("model_hit",   int'(hit_slot),         exp_cur.hit);
            check("model_valid", int'(pixel_addr_valid), exp_cur.valid);
        end
    end

    task automatic write_slot(input int idx, input int x, input int y,
                              input int code, input bit vis, input bit blink);
        @(negedge clk);
        slot_we    = 1'b1;
        slot_idx   = 4'(idx);
        slot_x     = 10'(x);
        slot_y     = 10'(y);
        slot_code  = 4'(code);
        slot_vis   = vis;
        slot_blink = blink;
        @(negedge clk);
        slot_we = 1'b0;
    endtask

    task automatic pixel(input string name, input int h, input int v,
                         input int exp_addr, input int exp_hit);
        @(negedge clk);
        h_cnt      = 10'(h);
        v_cnt      = 10'(v);
        scan_valid = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_early_valid"}, int'(pixel_addr_valid), 0);
        @(negedge clk);
        scan_valid = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_addr"},  int'(pixel_addr),       exp_addr);
        check({name, "_hit"},   int'(hit_slot),         exp_hit);
        check({name, "_valid"}, int'(pixel_addr_valid), 1);
    endtask

    function automatic logic [9:0] rand_pos();
        if ($urandom_range(0, 7) == 0) return 10'($urandom_range(1000, 1023));
        return 10'($urandom_range(0, 120));
    endfunction

    initial begin
        rst = 1'b1; h_cnt = '0; v_cnt = '0; scan_valid = 1'b0;
        slot_we = 1'b0; slot_idx = '0; slot_x = '0; slot_y = '0;
        slot_code = '0; slot_vis = 1'b0; slot_blink = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_addr",  int'(pixel_addr),       BG);
        check("reset_hit",   int'(hit_slot),         15);
        check("reset_valid", int'(pixel_addr_valid), 0);

        pixel("empty", 10, 10, 100, 15);

        write_slot(0, 135, 140, 3, 1'b1, 1'b0);
        pixel("slot0", 140, 145, 24765, 0);

        write_slot(2, 290, 140, 7, 1'b1, 1'b0);
        write_slot(5, 295, 145, 10, 1'b1, 1'b0);
        pixel("overlap", 300, 150, 26480, 2);

        write_slot(4, 100, 300, 0, 1'b1, 1'b0);
        pixel("edge_h99",  99,  305, 100,   15);
        pixel("edge_h120", 120, 305, 100,   15);
        pixel("edge_h100", 100, 305, 24680, 4);
        pixel("edge_h119", 119, 305, 24699, 4);

        // Write slot 1 in the same cycle its area is scanned.
        write_slot(1, 400, 100, 2, 1'b1, 1'b0);
        @(negedge clk);
        h_cnt = 10'd405; v_cnt = 10'd105; scan_valid = 1'b1;
        slot_we = 1'b1; slot_idx = 4'd1; slot_x = 10'd400; slot_y = 10'd100;
        slot_code = 4'd8; slot_vis = 1'b1; slot_blink = 1'b0;
        @(negedge clk);
        slot_we = 1'b0;
        @(posedge clk);
        #1;
        check("samecyc_old_addr", int'(pixel_addr), 24740);
        check("samecyc_old_hit",  int'(hit_slot),   1);
        @(negedge clk);
        scan_valid = 1'b0;
        @(posedge clk);
        #1;
        check("samecyc_new_addr", int'(pixel_addr), 45805);
        check("samecyc_new_hit",  int'(hit_slot),   1);

        write_slot(13, 0, 0, 0, 1'b1, 1'b0);
        pixel("idx13_ignored", 5, 5, 100, 15);

        write_slot(3, 200, 200, 1, 1'b1, 1'b1);
        pixel("blink_f0", 205, 203, 24077, 3);
        @(negedge clk);
        h_cnt = '0; v_cnt = '0; scan_valid = 1'b1;
        repeat (32) @(negedge clk);
        scan_valid = 1'b0;
`ifdef GLYPH_TILE_BLINK_EN
        pixel("blink_f32", 205, 203, 100, 15);
`else
        pixel("blink_f32", 205, 203, 24077, 3);
`endif
        @(negedge clk);
        h_cnt = '0; v_cnt = '0; scan_valid = 1'b1;
        repeat (32) @(negedge clk);
        scan_valid = 1'b0;
        pixel("blink_f64", 205, 203, 24077, 3);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst        = ($urandom_range(0, 499) == 0);
            slot_we    = ($urandom_range(0, 3) == 0);
            slot_idx   = 4'($urandom_range(0, 15));
            slot_x     = rand_pos();
            slot_y     = rand_pos();
            slot_code  = 4'($urandom_range(0, 15));
            slot_vis   = ($urandom_range(0, 3) != 0);
            slot_blink = 1'($urandom_range(0, 1));
            scan_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                h_cnt = '0;
                v_cnt = '0;
            end else begin
                h_cnt = rand_pos();
                v_cnt = rand_pos();
            end
        end
        @(negedge clk);
        rst = 1'b0; slot_we = 1'b0; scan_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
